// File: rtl/polar_pkg.sv
// Shared constants and types for the polar magnitude path.
// The result struct is also consumed by the downstream r/theta register stage.
package polar_pkg;

    localparam int RAD_W  = 16;
    localparam int ROOT_W = 8;
    localparam int REM_W  = 9;
    localparam int ITER   = 8;
    localparam int PREM_W = REM_W + 1;
    localparam int CNT_W  = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef struct packed {
        logic [ROOT_W-1:0] root;
        logic [REM_W-1:0]  rem;
    } polar_res_t;

    // Round-to-nearest from the floor root and remainder, saturating at the top code.
    function automatic logic [ROOT_W-1:0] round_root(input logic [ROOT_W-1:0] root,
                                                     input logic [PREM_W-1:0] rem);
        if (({2'b00, root} < rem) && (root != {ROOT_W{1'b1}})) begin
            return root + 8'd1;
        end
        return root;
    endfunction

endpackage

// File: rtl/polar_isqrt_step.sv
// One restoring square-root digit step: brings down two radicand bits and
// tries to append a 1 to the partial root.
module polar_isqrt_step
    import polar_pkg::*;
(
    input  logic [PREM_W-1:0] rem_i,
    input  logic [ROOT_W-1:0] root_i,
    input  logic [1:0]        bits_i,
    output logic [PREM_W-1:0] rem_o,
    output logic [ROOT_W-1:0] root_o
);

    logic [PREM_W+1:0] rem_sh;
    logic [PREM_W+1:0] trial;

    always_comb begin
        rem_sh = {rem_i, bits_i};
        trial  = {2'b00, root_i, 2'b01};
        // A successful trial leaves rem <= 2*root, so the low bits hold the exact difference.
        if (rem_sh >= trial) begin
            rem_o  = rem_sh[PREM_W-1:0] - trial[PREM_W-1:0];
            root_o = {root_i[ROOT_W-2:0], 1'b1};
        end else begin
            rem_o  = rem_sh[PREM_W-1:0];
            root_o = {root_i[ROOT_W-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/polar_isqrt.sv
// Iterative 16-bit integer square root, one digit per cycle, one operand in flight.
// Define POLAR_ISQRT_ROUND_EN to round out_root to nearest (out_rem stays the floor remainder).
module polar_isqrt
    import polar_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [RAD_W-1:0]    in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [ROOT_W-1:0]   out_root,
    output logic [REM_W-1:0]    out_rem,
    output logic                busy
);

    // Handshakes: a transfer happens on a rising edge where valid && ready;
    // valid never waits on ready, and the producer holds its data until the transfer.

    state_e             state_q, state_d;
    logic [RAD_W-1:0]   rad_q, rad_d;
    logic [PREM_W-1:0]  rem_q, rem_d;
    logic [ROOT_W-1:0]  root_q, root_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    polar_res_t         res_q, res_d;
    logic               out_valid_q, out_valid_d;
    logic               in_ready_q, in_ready_d;
    logic               busy_q, busy_d;

    logic [PREM_W-1:0]  step_rem;
    logic [ROOT_W-1:0]  step_root;

    polar_isqrt_step u_step (
        .rem_i  (rem_q),
        .root_i (root_q),
        .bits_i (rad_q[RAD_W-1:RAD_W-2]),
        .rem_o  (step_rem),
        .root_o (step_root)
    );

    always_comb begin
        state_d     = state_q;
        rad_d       = rad_q;
        rem_d       = rem_q;
        root_d      = root_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        out_valid_d = out_valid_q;
        in_ready_d  = in_ready_q;
        busy_d      = busy_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    rad_d      = in_data;
                    rem_d      = '0;
                    root_d     = '0;
                    cnt_d      = CNT_W'(ITER - 1);
                    state_d    = CALC;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            CALC: begin
                rem_d  = step_rem;
                root_d = step_root;
                rad_d  = {rad_q[RAD_W-3:0], 2'b00};
                cnt_d  = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    res_d.rem   = step_rem[REM_W-1:0];
`ifdef POLAR_ISQRT_ROUND_EN
                    res_d.root  = round_root(step_root, step_rem);
`else
                    res_d.root  = step_root;
`endif
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d     = IDLE;
                out_valid_d = 1'b0;
                in_ready_d  = 1'b1;
                busy_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rad_q       <= '0;
            rem_q       <= '0;
            root_q      <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rad_q       <= rad_d;
            rem_q       <= rem_d;
            root_q      <= root_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            out_valid_q <= out_valid_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_root  = res_q.root;
    assign out_rem   = res_q.rem;
    assign busy      = busy_q;

endmodule

// File: tb/tb_polar_isqrt.sv
// Self-checking bench for polar_isqrt: vector table, latency/backpressure/reset
// sequences and a randomised stream, all checked through an expected-result queue.
module tb_polar_isqrt;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_root;
    logic [8:0]  out_rem;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    logic [16:0] exp_q[$];
    bit stream_done = 0;

    typedef struct {
        logic [15:0] din;
        logic [7:0]  root;
        logic [8:0]  rem;
    } vec_t;

    vec_t vecs[12];

    polar_isqrt dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_root  (out_root),
        .out_rem   (out_rem),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Expected output from a floor root/remainder pair, rounding when enabled.
    function automatic logic [16:0] expect_of(input logic [7:0] root, input logic [8:0] rem);
        logic [7:0] r;
        r = root;
`ifdef POLAR_ISQRT_ROUND_EN
        if ({1'b0, root} < rem && root != 8'd255) r = root + 8'd1;
`endif
        return {r, rem};
    endfunction

    // Independent floor-sqrt model by linear search.
    function automatic logic [16:0] model(input logic [15:0] x);
        int r;
        int rem;
        r = 0;
        while ((r + 1) * (r + 1) <= int'(x)) r++;
        rem = int'(x) - r * r;
        return expect_of(8'(r), 9'(rem));
    endfunction

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] din, input logic [16:0] exp, output bit ok);
        int n;
        n = 0;
        ok = 0;
        in_data  = din;
        in_valid = 1'b1;
        while (!ok && n < 64) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(exp);
                ok = 1;
            end
            @(posedge clk);
            #1;
            n++;
        end
        in_valid = 1'b0;
        if (!ok) check("send_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (!out_valid && n < 64) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (!out_valid) check(name, 32'd0, 32'd1);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                check("out_root", 32'(out_root), 32'(e[16:9]));
                check("out_rem", 32'(out_rem), 32'(e[8:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit ok;
        int cyc;
        bit saw_valid;
        logic [16:0] e;

        vecs[0]  = '{16'd0,     8'd0,   9'd0};
        vecs[1]  = '{16'd1,     8'd1,   9'd0};
        vecs[2]  = '{16'd3,     8'd1,   9'd2};
        vecs[3]  = '{16'd200,   8'd14,  9'd4};
        vecs[4]  = '{16'd210,   8'd14,  9'd14};
        vecs[5]  = '{16'd211,   8'd14,  9'd15};
        vecs[6]  = '{16'd255,   8'd15,  9'd30};
        vecs[7]  = '{16'd256,   8'd16,  9'd0};
        vecs[8]  = '{16'd1024,  8'd32,  9'd0};
        vecs[9]  = '{16'd65025, 8'd255, 9'd0};
        vecs[10] = '{16'd65535, 8'd255, 9'd510};
        vecs[11] = '{16'd12345, 8'd111, 9'd24};

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_root", 32'(out_root), 32'd0);
        check("rst_out_rem", 32'(out_rem), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Latency: result must appear exactly 8 edges after the accept edge.
        send(16'd0, expect_of(8'd0, 9'd0), ok);
        cyc = 0;
        while (!out_valid && cyc < 20) begin
            check("lat_in_ready_low", 32'(in_ready), 32'd0);
            check("lat_busy_high", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
            cyc++;
        end
        check("latency_cycles", 32'(cyc), 32'd8);
        check("done_in_ready_low", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        drain("drain_zero");

        // Backpressure: hold out_ready low, outputs must stay stable.
        out_ready = 1'b0;
        e = expect_of(8'd14, 9'd4);
        send(16'd200, e, ok);
        wait_out_valid("bp_out_valid_timeout");
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_root_stable", 32'(out_root), 32'(e[16:9]));
            check("bp_rem_stable", 32'(out_rem), 32'(e[8:0]));
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("hs_out_valid_drop", 32'(out_valid), 32'd0);
        check("hs_in_ready_rise", 32'(in_ready), 32'd1);
        check("hs_busy_drop", 32'(busy), 32'd0);
        check("hs_queue_empty", 32'(exp_q.size()), 32'd0);

        // Vector table with out_ready held high.
        for (int i = 0; i < 12; i++) begin
            send(vecs[i].din, expect_of(vecs[i].root, vecs[i].rem), ok);
            drain("drain_table");
        end

        // Reset in the middle of CALC discards the operand.
        out_ready = 1'b0;
        send(16'd1024, expect_of(8'd32, 9'd0), ok);
        repeat (3) @(posedge clk);
        #1;
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_out_root", 32'(out_root), 32'd0);
        check("abort_out_rem", 32'(out_rem), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saw_valid = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) saw_valid = 1;
        end
        check("abort_no_result", 32'(saw_valid), 32'd0);
        out_ready = 1'b1;
        send(16'd1024, expect_of(8'd32, 9'd0), ok);
        drain("drain_after_abort");

        // Random stream with random in_valid gaps and out_ready backpressure.
        fork
            begin
                for (int i = 0; i < 200; i++) begin
                    logic [15:0] d;
                    int gap;
                    gap = $urandom_range(0, 3);
                    for (int g = 0; g < gap; g++) begin
                        in_data = 16'($urandom_range(0, 65535));
                        @(posedge clk);
                        #1;
                    end
                    d = 16'($urandom_range(0, 65535));
                    send(d, model(d), ok);
                end
                stream_done = 1;
            end
            begin
                while (!stream_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain("drain_random");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
